// File: rtl/fetch_queue.sv
// Instruction fetch front-end: one outstanding imem request, 2-entry {pc, insn} queue to decode.
// Optional misaligned-redirect fault when FETCH_ALIGN_CHECK_EN is defined.
module fetch_queue #(
  parameter logic [0:31] RESET_PC = 32'h8002_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        imem_rd,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_rdata,
  output logic [0:31] insn,
  output logic [0:31] pc,
  output logic        valid_insn,
  output logic        fetch_fault
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [0:XLEN-1] pc;
    logic [0:XLEN-1] insn;
  } entry_t;

  state_e            state_q, state_d;
  logic [0:XLEN-1]   fetch_pc_q, fetch_pc_d;
  logic [0:XLEN-1]   addr_q, addr_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  entry_t            entry_q [2];

  entry_t            head;
  logic              empty;
  logic              push;
  logic              pop;
  logic              flush;
  logic              misalign;
  logic [0:XLEN-1]   target_pc;
  logic [CNT_W-1:0]  cnt_after_pop;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign    = |redirect_pc[30:31];
  assign target_pc   = redirect_pc;
  assign fetch_fault = (state_q == S_FAULT);
`else
  assign misalign    = 1'b0;
  assign target_pc   = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_fault = 1'b0;
`endif

  // Head-of-queue presentation; decode samples on the same edge that pops.
  assign empty      = (cnt_q == '0);
  assign head       = entry_q[rd_ptr_q];
  assign valid_insn = !empty && !stall && !redirect && (state_q != S_FAULT);
  assign insn       = empty ? '0 : head.insn;
  assign pc         = empty ? '0 : head.pc;
  assign imem_rd    = (state_q == S_WAIT) || ((state_q == S_FAULT) && drop_q);
  assign imem_addr  = addr_q;

  assign pop           = valid_insn;
  assign flush         = redirect && (state_q != S_FAULT);
  assign cnt_after_pop = cnt_q - CNT_W'(pop);

  // Next-state: request sequencing, queue bookkeeping and redirect handling.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    push       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!redirect && (cnt_after_pop < DEPTH)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!redirect) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            if ((cnt_after_pop + CNT_W'(1)) >= DEPTH) state_d = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        if (imem_ack) drop_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // An unacknowledged request keeps running; its data is discarded on arrival.
    if (flush) begin
      fetch_pc_d = target_pc;
      drop_d     = (state_q == S_WAIT) && !imem_ack;
      if (misalign) state_d = S_FAULT;
    end

    if (flush) begin
      cnt_d    = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end

    addr_d = (imem_rd && !imem_ack) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      entry_q[0] <= '0;
      entry_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) entry_q[wr_ptr_q] <= {fetch_pc_q, imem_rdata};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory model returning addr^K, scoreboard of expected deliveries.
// Covers the FETCH_ALIGN_CHECK_EN fault path when that macro is defined.
module tb_fetch_queue;

  localparam logic [31:0] K      = 32'h1234_5678;
  localparam logic [31:0] RST_PC = 32'h8002_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [0:31] redirect_pc;
  logic        imem_rd;
  logic [0:31] imem_addr;
  logic        imem_ack;
  logic [0:31] imem_rdata;
  logic [0:31] insn;
  logic [0:31] pc;
  logic        valid_insn;
  logic        fetch_fault;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   lat      = 0;
  int   wait_cnt = 0;
  logic force_ack = 1'b0;
  exp_t exp_q [$];

  fetch_queue #(.RESET_PC(32'h8002_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_rd     (imem_rd),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .insn        (insn),
    .pc          (pc),
    .valid_insn  (valid_insn),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory: acks after `lat` wait cycles; force_ack injects a stray ack with junk data.
  assign imem_ack   = force_ack | (imem_rd && (wait_cnt >= lat));
  assign imem_rdata = force_ack ? 32'hDEAD_BEEF : (imem_addr ^ K);

  always @(posedge clk) wait_cnt <= (imem_rd && !imem_ack) ? wait_cnt + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_push(input logic [31:0] p);
    exp_q.push_back({p, p ^ K});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) next_cycle();
  endtask

  // Monitor: scoreboard compare on every delivery, plus address stability per request.
  logic [31:0] req_addr = '0;
  bit          in_req   = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid_insn) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got pc %h insn %h, expected no delivery (cycle %0d)", pc, insn, cyc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", pc, e.pc);
        check("sb_insn", insn, e.insn);
      end
    end
    if (imem_rd) begin
      if (in_req) check("addr_stable", imem_addr, req_addr);
      else        req_addr = imem_addr;
      in_req = !imem_ack;
    end else begin
      in_req = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd", imem_rd, 1'b0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_insn", insn, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", valid_insn, 1'b0);
    check("rst_fault", fetch_fault, 1'b0);

    // Zero-wait stream, then 5-cycle stall and release.
    @(posedge clk); #1;
    rst_n = 1'b1; cyc = 0;
    for (int i = 0; i < 7; i++) exp_push(RST_PC + 32'(4 * i));
    @(negedge clk);
    check("c0_rd", imem_rd, 1'b0);
    check("c0_valid", valid_insn, 1'b0);
    goto(1); @(negedge clk);
    check("c1_rd", imem_rd, 1'b1);
    check("c1_addr", imem_addr, RST_PC);
    check("c1_valid", valid_insn, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      goto(k); @(negedge clk);
      check("stream_valid", valid_insn, 1'b1);
    end
    goto(6); stall = 1'b1;
    goto(8); @(negedge clk);
    check("stall_rd", imem_rd, 1'b0);
    check("stall_valid", valid_insn, 1'b0);
    check("stall_head_pc", pc, 32'h8002_0010);
    check("stall_head_insn", insn, 32'h8002_0010 ^ K);
    goto(11); stall = 1'b0;
    @(negedge clk); check("release_valid0", valid_insn, 1'b1);
    goto(12); @(negedge clk); check("release_valid1", valid_insn, 1'b1);

    // Three wait cycles per request: one delivery every 4 cycles.
    goto(13); lat = 3;
    exp_push(32'h8002_001C); exp_push(32'h8002_0020); exp_push(32'h8002_0024);
    @(negedge clk); check("release_valid2", valid_insn, 1'b1);
    for (int k = 14; k <= 25; k++) begin
      goto(k); @(negedge clk);
      check("slow_valid", valid_insn, (k == 17 || k == 21 || k == 25));
    end

    // Redirect while the request to 80020028 is still waiting.
    goto(26); redirect = 1'b1; redirect_pc = 32'h8002_1000;
    exp_push(32'h8002_1000); exp_push(32'h8002_1004); exp_push(32'h8002_1008);
    @(negedge clk); check("redir_valid", valid_insn, 1'b0);
    goto(27); redirect = 1'b0;
    @(negedge clk);
    check("drop_rd", imem_rd, 1'b1);
    check("drop_addr_old", imem_addr, 32'h8002_0028);
    goto(29); @(negedge clk);
    check("drop_rd_new", imem_rd, 1'b1);
    check("drop_addr_new", imem_addr, 32'h8002_1000);
    goto(37); lat = 0;

    // Redirect coinciding with an ack while the queue holds an entry.
    goto(39); redirect = 1'b1; redirect_pc = 32'h8003_0000;
    exp_push(32'h8003_0000);
    @(negedge clk);
    check("ackredir_rd", imem_rd, 1'b1);
    check("ackredir_head", pc, 32'h8002_100C);
    check("ackredir_valid", valid_insn, 1'b0);
    goto(40); redirect = 1'b0;
    @(negedge clk);
    check("flush_valid", valid_insn, 1'b0);
    check("flush_pc", pc, 32'h0);
    check("flush_insn", insn, 32'h0);
    check("flush_addr", imem_addr, 32'h8003_0000);

    // Reset mid-request, then a stray ack while idle.
    goto(41); lat = 3;
    goto(42); rst_n = 1'b0;
    exp_push(RST_PC); exp_push(RST_PC + 32'd4);
    @(negedge clk);
    check("midrst_rd", imem_rd, 1'b0);
    check("midrst_addr", imem_addr, RST_PC);
    goto(43); rst_n = 1'b1; force_ack = 1'b1; lat = 0;
    @(negedge clk);
    check("stray_rd", imem_rd, 1'b0);
    check("stray_valid", valid_insn, 1'b0);
    goto(44); force_ack = 1'b0;
    @(negedge clk);
    check("stray_ignored", valid_insn, 1'b0);
    check("restart_rd", imem_rd, 1'b1);
    goto(47); stall = 1'b1;

    // Misaligned redirect from a full, idle queue.
    goto(50); redirect = 1'b1; redirect_pc = 32'h8002_1002;
`ifdef FETCH_ALIGN_CHECK_EN
    goto(51); redirect = 1'b0; stall = 1'b0;
    for (int k = 51; k <= 55; k++) begin
      goto(k); @(negedge clk);
      check("fault_flag", fetch_fault, 1'b1);
      check("fault_rd", imem_rd, 1'b0);
      check("fault_valid", valid_insn, 1'b0);
    end
    goto(56); rst_n = 1'b0;
    exp_push(RST_PC); exp_push(RST_PC + 32'd4);
    @(negedge clk); check("fault_cleared", fetch_fault, 1'b0);
    goto(57); rst_n = 1'b1;
    goto(61); stall = 1'b1;
`else
    exp_push(32'h8002_1000); exp_push(32'h8002_1004);
    @(negedge clk); check("nofault_flag", fetch_fault, 1'b0);
    goto(51); redirect = 1'b0; stall = 1'b0;
    goto(52); @(negedge clk);
    check("align_rd", imem_rd, 1'b1);
    check("align_addr", imem_addr, 32'h8002_1000);
    goto(55); stall = 1'b1;
`endif

    goto(65); @(negedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
